// File: rtl/div_display_unit.sv
// rtl/div_display_unit.sv - 4-bit restoring divider with 8-digit multiplexed 7-segment scan
// Quotient/remainder of sw[3:0]/sw[7:4]; digit 0 shows quotient, digit 1 remainder.
module div_display_unit #(
    parameter int CLK_HZ  = 100000000,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       init,
    output logic [3:0] resultado,
    output logic [3:0] residuo,
    output logic       done,
    output logic       tick,
    output logic [6:0] sseg,
    output logic [7:0] anodos
);
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d;
    logic [2:0]       step_q, step_d;
    logic [3:0]       res_q, res_d, rem_q, rem_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic [2:0]       idx_q;

    logic [4:0] r_shift, b_ext;
    logic       qbit;
    logic [3:0] r_next;

    // Partial remainder is always < B, so the shifted value fits in 5 bits and the
    // difference fits back into 4.
    assign r_shift = {r_q, a_q[3]};
    assign b_ext   = {1'b0, b_q};
    assign qbit    = (r_shift >= b_ext);
    assign r_next  = qbit ? 4'(r_shift - b_ext) : r_shift[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            step_q  <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            q_q     <= q_d;
            step_q  <= step_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        q_d     = q_q;
        step_d  = step_q;
        res_d   = res_q;
        rem_d   = rem_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (init) begin
                    a_d     = sw[3:0];
                    b_d     = sw[7:4];
                    r_d     = '0;
                    q_d     = '0;
                    step_d  = '0;
                    done_d  = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Four shift/subtract cycles, then one cycle to publish the result.
                if (step_q == 3'd4) begin
                    res_d   = q_q;
                    rem_d   = r_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    r_d    = r_next;
                    q_d    = {q_q[2:0], qbit};
                    a_d    = {a_q[2:0], 1'b0};
                    step_d = step_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                tick_q <= 1'b0;
            end
            if (tick_q) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        sseg = 7'h7F;
        if (idx_q == 3'd0) begin
            sseg = done_q ? hex7(res_q) : 7'h3F;
        end else if (idx_q == 3'd1) begin
            sseg = done_q ? hex7(rem_q) : 7'h3F;
        end
    end

    assign anodos    = ~(8'b1 << idx_q);
    assign resultado = res_q;
    assign residuo   = rem_q;
    assign done      = done_q;
    assign tick      = tick_q;
endmodule

// File: tb/tb_div_display_unit.sv
// tb/tb_div_display_unit.sv - directed bench for div_display_unit with an 8-cycle scan ratio
module tb_div_display_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       init = 1'b0;
    logic [3:0] resultado, residuo;
    logic       done, tick;
    logic [6:0] sseg;
    logic [7:0] anodos;

    int tests = 0;
    int fails = 0;

    logic [6:0] hexs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0] an_seq [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};

    div_display_unit #(.CLK_HZ(8), .SCAN_HZ(1)) dut (
        .clk(clk), .rst(rst), .sw(sw), .init(init),
        .resultado(resultado), .residuo(residuo), .done(done), .tick(tick),
        .sseg(sseg), .anodos(anodos)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_anode(input logic [7:0] an, output bit ok);
        int n = 0;
        while (anodos !== an && n < 80) begin
            step();
            n++;
        end
        ok = (anodos === an);
    endtask

    task automatic test_reset();
        init = 1'b0;
        sw   = 8'h00;
        rst  = 1'b1;
        #23;
        tests++; if (resultado !== 4'h0) begin fails++; $display("FAIL reset_resultado got %h want 0", resultado); end
        tests++; if (residuo !== 4'h0)   begin fails++; $display("FAIL reset_residuo got %h want 0", residuo); end
        tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (tick !== 1'b0)      begin fails++; $display("FAIL reset_tick got %b want 0", tick); end
        tests++; if (anodos !== 8'hFE)   begin fails++; $display("FAIL reset_anodos got %h want fe", anodos); end
        tests++; if (sseg !== 7'h3F)     begin fails++; $display("FAIL reset_sseg got %h want 3f", sseg); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int n;
        apply_reset();
        for (int s = 1; s <= 8; s++) begin
            n = 0;
            while (!tick && n < 20) begin
                step();
                n++;
            end
            tests++;
            if (n !== ((s == 1) ? 8 : 7)) begin
                fails++; $display("FAIL scan_tick_period step %0d got %0d want %0d", s, n, (s == 1) ? 8 : 7);
            end
            step();
            tests++; if (tick !== 1'b0) begin fails++; $display("FAIL scan_tick_width step %0d got %b want 0", s, tick); end
            tests++;
            if (anodos !== an_seq[s]) begin
                fails++; $display("FAIL scan_anodos step %0d got %h want %h", s, anodos, an_seq[s]);
            end
            tests++;
            if (sseg !== ((s % 8 < 2) ? 7'h3F : 7'h7F)) begin
                fails++; $display("FAIL scan_sseg step %0d got %h want %h", s, sseg, (s % 8 < 2) ? 7'h3F : 7'h7F);
            end
        end
    endtask

    task automatic test_divide(input logic [7:0] s, input logic [3:0] eq, input logic [3:0] er);
        bit ok;
        @(negedge clk);
        sw = s;
        init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            tests++;
            if (done !== (i == 5)) begin
                fails++; $display("FAIL div_latency sw=%h edge %0d got done=%b want %b", s, i, done, i == 5);
            end
        end
        tests++; if (resultado !== eq) begin fails++; $display("FAIL div_quot sw=%h got %h want %h", s, resultado, eq); end
        tests++; if (residuo !== er)   begin fails++; $display("FAIL div_rem sw=%h got %h want %h", s, residuo, er); end
        wait_anode(8'hFE, ok);
        tests++;
        if (!ok || sseg !== hexs[eq]) begin
            fails++; $display("FAIL div_digit0 sw=%h got %h want %h", s, sseg, hexs[eq]);
        end
        wait_anode(8'hFD, ok);
        tests++;
        if (!ok || sseg !== hexs[er]) begin
            fails++; $display("FAIL div_digit1 sw=%h got %h want %h", s, sseg, hexs[er]);
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL div_hold sw=%h got done=%b want 1", s, done); end
    endtask

    task automatic test_init_during_calc();
        @(negedge clk);
        sw = 8'h3D;
        init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init = 1'b0;
        step();
        sw = 8'h52;
        init = 1'b1;
        step();
        init = 1'b0;
        step();
        step();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL calc_busy got done=%b want 0", done); end
        step();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL calc_ignore_done got %b want 1", done); end
        tests++; if (resultado !== 4'h4) begin fails++; $display("FAIL calc_ignore_quot got %h want 4", resultado); end
        tests++; if (residuo !== 4'h1)   begin fails++; $display("FAIL calc_ignore_rem got %h want 1", residuo); end
        repeat (10) step();
        tests++;
        if (done !== 1'b1 || resultado !== 4'h4 || residuo !== 4'h1) begin
            fails++; $display("FAIL done_hold got %b/%h/%h want 1/4/1", done, resultado, residuo);
        end
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        sw = 8'h1F;
        init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rst_mid_done got %b want 0", done); end
        tests++; if (resultado !== 4'h0) begin fails++; $display("FAIL rst_mid_quot got %h want 0", resultado); end
        tests++; if (anodos !== 8'hFE)   begin fails++; $display("FAIL rst_mid_anodos got %h want fe", anodos); end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_stays_idle got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_divide(8'h3D, 4'h4, 4'h1);
        test_divide(8'h1F, 4'hF, 4'h0);
        test_divide(8'h52, 4'h0, 4'h2);
        test_divide(8'h0B, 4'hF, 4'hB);
        test_divide(8'hF0, 4'h0, 4'h0);
        test_init_during_calc();
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div_display_unit.md
Name: div_display_unit

Overview:
- Board-level arithmetic/display block.
- Divides the low switch nibble by the high switch nibble with a sequential restoring divider.
- Generates a scan-rate tick from the system clock and multiplexes the quotient and remainder onto an 8-digit, active-low, common-anode 7-segment display.
- Sits directly under the top-level wrapper. The wrapper supplies switches and a one-cycle start pulse, and drives LEDs from the quotient.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance tick rate in Hz. Tick period is CLK_HZ/SCAN_HZ clk cycles; benches override this to a ratio of 8.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw  input  8  operands: sw[3:0] is the dividend, sw[7:4] is the divisor.
- init  input  1  start pulse; synchronous, sampled on clk.
- resultado  output  4  quotient.
- residuo  output  4  remainder.
- done  output  1  high while resultado/residuo hold a valid result.
- tick  output  1  one-clk-wide pulse at SCAN_HZ.
- sseg  output  7  segments {g,f,e,d,c,b,a}, active low.
- anodos  output  8  digit enables, active low; anodos[0] is the rightmost digit.

Behaviour:
Reset (asynchronous, while rst=1):
- resultado=0, residuo=0, done=0, tick=0.
- Divider goes to IDLE; prescaler counter cleared.
- Scan index = 0, so anodos=8'hFE and sseg=7'h3F (dash, because done=0).

Prescaler:
- Counter runs 0..(CLK_HZ/SCAN_HZ−1).
- tick=1 for exactly the one cycle in which the counter wraps to 0. The first tick occurs CLK_HZ/SCAN_HZ cycles after reset release.
- Single clock domain: no derived clocks; tick is an enable only.

Divider FSM (states IDLE, CALC, DONE):
- IDLE/DONE with init=1 at an edge:
  - latch A=sw[3:0] and B=sw[7:4];
  - clear the partial remainder and the step counter (4 steps);
  - done←0;
  - go to CALC.
- CALC, one quotient bit per cycle, MSB first:
  - R←{R[2:0],A[msb]};
  - if R≥B then R←R−B and qbit=1, else qbit=0.
  - Use a 5-bit compare/subtract path; no overflow is possible.
- After the 4th CALC cycle:
  - resultado←Q, residuo←R, done←1;
  - go to DONE.
- Latency: init sampled at edge k gives done=1 visible after edge k+5.
- Divide by zero (B=0): the restoring algorithm yields resultado=4'hF and residuo=A; no special path is required, and these values are mandatory.
- init during CALC is ignored.
- sw changes after the latch do not affect the running operation.
- done stays 1 and outputs hold indefinitely in DONE until the next init.
- init in DONE restarts; done drops on the next edge.
- rst mid-CALC aborts immediately to the reset values.

Display scan:
- Scan index (3 bits) increments on each tick, 7 wraps to 0.
- Exactly one anode is low at a time: anodos = ~(1<<index).
- Digit 0 shows resultado in hex; digit 1 shows residuo in hex.
- Digits 2–7 are blank: sseg=7'h7F, with the anode still asserted per scan.
- While done=0, digits 0–1 show a dash, 7'h3F.
- Hex codes, active low:
  - 0=40, 1=79, 2=24, 3=30;
  - 4=19, 5=12, 6=02, 7=78;
  - 8=00, 9=10, A=08, b=03;
  - C=46, d=21, E=06, F=0E.
- sseg/anodos are combinational from the scan index, done and the results; glitches are allowed only at index change.

Test Plan:
- sw=8'h3D (13÷3), pulse init → done rises exactly 5 edges later; resultado=4, residuo=1; digit0 sseg=19, digit1 sseg=79.
- sw=8'h1F (15÷1) → resultado=F, residuo=0. sw=8'h52 (2÷5) → resultado=0, residuo=2.
- sw=8'h0B (divisor 0) → resultado=F, residuo=B, done=1.
- Scan with ratio 8 → tick every 8 cycles; anodos sequence FE,FD,FB,F7,EF,DF,BF,7F,FE; digits 2–7 give sseg=7F; digits 0–1 give 3F before the first done.
- Raise init again during CALC and change sw → result matches the originally latched operands. Assert rst mid-CALC → done=0, resultado=0, anodos=FE immediately, without waiting for a clk edge.
